// File: rtl/colparity_ctrl_if.sv
// rtl/colparity_ctrl_if.sv - lane memory, accumulator and parity output bus of the column-parity sequencer
interface colparity_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int COL_W  = 3
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              acc_clr;
  logic              acc_en;
  logic [COL_W-1:0]  acc_col;
  logic              out_valid;
  logic              out_ready;
  logic [COL_W-1:0]  out_col;

  modport master (
    output mem_rd_en,
    output mem_addr,
    output acc_clr,
    output acc_en,
    output acc_col,
    output out_valid,
    output out_col,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    input  acc_clr,
    input  acc_en,
    input  acc_col,
    input  out_valid,
    input  out_col,
    output out_ready
  );
endinterface

// File: rtl/colparity_ctrl.sv
// rtl/colparity_ctrl.sv - sequencer clearing, filling and draining the five column parity accumulators
module colparity_ctrl #(
  parameter int NUM_COLS = 5,
  parameter int NUM_ROWS = 5,
  parameter int ADDR_W   = 5,
  parameter int COL_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  colparity_ctrl_if.master    dp
);

  localparam logic [ADDR_W-1:0] LAST_LANE = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lane_q, lane_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              acc_en_q;
  logic [COL_W-1:0]  acc_col_q;

  // acc_en/acc_col trail the read strobe by one stage to match the 1-cycle memory latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      col_q     <= '0;
      acc_en_q  <= 1'b0;
      acc_col_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      col_q     <= col_d;
      acc_en_q  <= (state_q == S_READ);
      acc_col_q <= (state_q == S_READ) ? col_q : '0;
    end
  end

  // col_q doubles as the output word index once the reads are finished
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        lane_d  = '0;
        col_d   = '0;
        state_d = S_READ;
      end
      S_READ: begin
        lane_d = lane_q + 1'b1;
        col_d  = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        if (lane_q == LAST_LANE) begin
          lane_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        col_d   = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (dp.out_ready) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = S_DONE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        lane_d  = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign dp.mem_rd_en = (state_q == S_READ);
  assign dp.mem_addr  = (state_q == S_READ) ? lane_q : '0;
  assign dp.acc_clr   = (state_q == S_CLEAR);
  assign dp.acc_en    = acc_en_q;
  assign dp.acc_col   = acc_col_q;
  assign dp.out_valid = (state_q == S_WRITE);
  assign dp.out_col   = (state_q == S_WRITE) ? col_q : '0;

endmodule
